instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, SHALL set the maximum WAIT-state cycles before a fetch fault; legal range 1..65535.
REQ-002 Parameter RESET_INSTR, default 32'h00000013 (NOP), SHALL set the value of instr while no fetched instruction is held.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 Areset  input  1  reset, asynchronous and active-low.
REQ-005 PC  input  32  current program counter from the PC register.
REQ-006 load  output  1  PC advance strobe, driven to the PC register's load input.
REQ-007 imem_req  output  1  instruction-memory request valid.
REQ-008 imem_addr  output  32  instruction-memory byte address.
REQ-009 imem_gnt  input  1  memory accepted the request this cycle.
REQ-010 imem_rvalid  input  1  read data valid this cycle.
REQ-011 imem_rdata  input  32  read data.
REQ-012 instr  output  32  instruction presented to decode.
REQ-013 instr_valid  output  1  instr is valid and held until consumed.
REQ-014 core_ready  input  1  decode consumes instr this cycle.
REQ-015 flush  input  1  discard outstanding or held fetch (redirect).
REQ-016 fetch_fault  output  1  sticky fault indicator.

Function
REQ-017 FSM states: IDLE, REQ, WAIT, VALID, DRAIN, FAULT; exactly one active.
REQ-018 IDLE: SHALL go to REQ on the first clock edge after reset release.
REQ-019 REQ: imem_req=1, imem_addr=PC (sampled combinationally); imem_gnt=1 -> WAIT; otherwise stay.
REQ-020 WAIT: imem_req=0; a wait counter increments each cycle; imem_rvalid=1 -> capture imem_rdata into instr, go to VALID, counter cleared.
REQ-021 WAIT: counter reaching TIMEOUT_CYCLES with imem_rvalid=0 -> FAULT.
REQ-022 VALID: instr_valid=1 and instr held stable until consumed.
REQ-023 VALID with core_ready=1 and flush=0: load=1 in that same cycle (combinational), next state REQ; the PC update is thereby visible on PC during REQ.
REQ-024 load SHALL be 1 only under REQ-023; never in any other state or cycle.
REQ-025 flush in REQ: no effect (imem_addr already tracks PC).
REQ-026 flush in WAIT: go to DRAIN; rvalid in the same cycle as flush SHALL also be discarded and go directly to REQ.
REQ-027 DRAIN: discard the next imem_rvalid beat, then go to REQ; the timeout counter also runs in DRAIN, with the same FAULT rule.
REQ-028 flush in VALID: drop instr (instr_valid=0, instr=RESET_INSTR), load=0, go to REQ; flush overrides core_ready.
REQ-029 FAULT: terminal until reset; fetch_fault=1, imem_req=0, instr_valid=0, load=0; all inputs ignored.
REQ-030 At most one outstanding memory request at any time.

Reset
REQ-031 Areset low SHALL immediately force: state IDLE, wait counter 0, instr=RESET_INSTR, instr_valid=0, imem_req=0, imem_addr=0, load=0, fetch_fault=0.
REQ-032 Reset mid-transaction SHALL abandon it; a late imem_rvalid arriving in IDLE or REQ SHALL be ignored.

Configuration
REQ-033 Macro FETCH_MISALIGN_CHECK_EN defined: in REQ, PC[1:0]!=2'b00 -> FAULT next cycle with imem_req=0 in that cycle.
REQ-034 Macro FETCH_MISALIGN_CHECK_EN undefined: no check; imem_addr = {PC[31:2],2'b00}.

Verification
REQ-035 Reset release, PC=0x0, gnt on 1st REQ cycle, rvalid 2 cycles later with 0x00500093 -> instr_valid=1, instr=0x00500093; core_ready=1 -> load pulse of exactly 1 cycle, next imem_addr=0x4.
REQ-036 core_ready held 0 for 5 cycles in VALID -> instr stable, load=0 throughout; core_ready=1 on 6th cycle -> single load pulse.
REQ-037 flush asserted 1 cycle after gnt, rvalid 3 cycles later with 0xDEADBEEF -> beat discarded, instr_valid never 1 for it, new request issued at current PC.
REQ-038 TIMEOUT_CYCLES=4, no rvalid after gnt -> fetch_fault=1 after the 4th WAIT cycle, remains 1; Areset pulse clears it and fetch restarts.
REQ-039 With FETCH_MISALIGN_CHECK_EN, PC=0x6 -> imem_req never asserted, fetch_fault=1; without it, imem_addr=0x4.
REQ-040 Areset asserted during WAIT -> all outputs at reset values asynchronously; late rvalid after release ignored.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit -- single-outstanding instruction fetch FSM.
// Issues one memory request at a time at the current PC and holds the returned
// word for decode until it is consumed. Decode consuming the word pulses load
// so the PC register advances. A flush redirect discards in-flight or held data.
// A response timeout in WAIT/DRAIN latches a terminal fault until reset.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN. When it is defined, a
// misaligned PC seen in REQ faults without issuing a request.
`timescale 1ns/1ps
module instr_fetch_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] RESET_INSTR    = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        Areset,
  input  logic [31:0] PC,
  output logic        load,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        core_ready,
  input  logic        flush,
  output logic        fetch_fault
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    VALID = 3'd3,
    DRAIN = 3'd4,
    FAULT = 3'd5
  } state_t;

  // Last count value still inside the timeout window
  localparam logic [15:0] LP_CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [31:0] r_instr;
  logic        r_instr_valid;
  logic        r_fault;
  logic        w_misalign;
  logic        w_timeout;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign w_misalign = (PC[1:0] != 2'b00);
`else
  assign w_misalign = 1'b0;
`endif

  assign w_timeout = (r_cnt >= LP_CNT_LAST);

  // Request, address and advance strobe track the live state and inputs
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = 32'h0;
    load      = 1'b0;
    if (r_state == REQ && !w_misalign) begin
      imem_req  = 1'b1;
      // Clearing the low bits gives word alignment; only aligned PCs get here when the check is on
      imem_addr = PC & 32'hFFFF_FFFC;
    end
    if (r_state == VALID && core_ready && !flush)
      load = 1'b1;
  end

  assign instr       = r_instr;
  assign instr_valid = r_instr_valid;
  assign fetch_fault = r_fault;

  // Fetch sequencer: state, wait counter, and the registered decode and fault outputs
  always_ff @(posedge clk or negedge Areset) begin
    if (!Areset) begin
      r_state       <= IDLE;
      r_cnt         <= 16'h0;
      r_instr       <= RESET_INSTR;
      r_instr_valid <= 1'b0;
      r_fault       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: r_state <= REQ;
        REQ: begin
          if (w_misalign) begin
            r_state <= FAULT;
            r_fault <= 1'b1;
          end else if (imem_gnt) begin
            r_state <= WAIT;
            r_cnt   <= 16'h0;
          end
        end
        WAIT: begin
          if (flush) begin
            // A beat that coincides with the flush is already stale, so skip DRAIN
            if (imem_rvalid) begin
              r_state <= REQ;
              r_cnt   <= 16'h0;
            end else begin
              r_state <= DRAIN;
              r_cnt   <= r_cnt + 16'd1;
            end
          end else if (imem_rvalid) begin
            r_state       <= VALID;
            r_instr       <= imem_rdata;
            r_instr_valid <= 1'b1;
            r_cnt         <= 16'h0;
          end else if (w_timeout) begin
            r_state <= FAULT;
            r_fault <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        DRAIN: begin
          if (imem_rvalid) begin
            r_state <= REQ;
            r_cnt   <= 16'h0;
          end else if (w_timeout) begin
            r_state <= FAULT;
            r_fault <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        VALID: begin
          // Flush and consume both release the word; only consume pulses load
          if (flush || core_ready) begin
            r_state       <= REQ;
            r_instr       <= RESET_INSTR;
            r_instr_valid <= 1'b0;
          end
        end
        FAULT: r_state <= FAULT;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit (TIMEOUT_CYCLES=4).
// The bench plays the role of both the memory and the PC register.
// Inputs change and outputs are sampled on the falling clock edge.
`timescale 1ns/1ps
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        Areset;
  logic [31:0] PC;
  logic        load;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        core_ready;
  logic        flush;
  logic        fetch_fault;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  instr_fetch_unit #(.TIMEOUT_CYCLES(4), .RESET_INSTR(32'h0000_0013)) dut (
    .clk(clk), .Areset(Areset), .PC(PC), .load(load),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid), .core_ready(core_ready),
    .flush(flush), .fetch_fault(fetch_fault)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Drive one read beat; accepted beats are expected at decode later
  task automatic beat(input logic [31:0] data, input bit accept);
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    if (accept) exp_q.push_back(data);
  endtask

  // Bounded wait for instr_valid, then compare against the oldest expected word
  task automatic wait_valid(input string tag);
    int n = 0;
    while (!instr_valid && n < 20) begin
      cyc();
      n++;
    end
    if (!instr_valid)
      chk({tag, "_timeout"}, 32'(instr_valid), 32'd1);
    else if (exp_q.size() == 0)
      chk({tag, "_unexpected"}, instr, 32'h0);
    else
      chk(tag, instr, exp_q.pop_front());
  endtask

  // Assert reset across a falling edge, then release it.
  // On return the DUT is in its first REQ cycle.
  task automatic do_reset();
    Areset = 1'b0;
    cyc();
    Areset = 1'b1;
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    Areset = 1'b0; PC = 32'h0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
    imem_rdata = 32'h0; core_ready = 1'b0; flush = 1'b0;
    cyc();
    chk("rst_instr", instr, 32'h13);
    chk("rst_ivld", 32'(instr_valid), 0);
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_load", 32'(load), 0);
    chk("rst_fault", 32'(fetch_fault), 0);

    // Basic fetch: grant in the first REQ cycle, data two WAIT cycles later
    Areset = 1'b1;
    cyc();
    chk("t1_req", 32'(imem_req), 1);
    chk("t1_addr", imem_addr, 32'h0);
    imem_gnt = 1'b1;
    cyc(); imem_gnt = 1'b0;
    chk("t1_wait_req", 32'(imem_req), 0);
    cyc();
    beat(32'h0050_0093, 1'b1);
    cyc(); imem_rvalid = 1'b0;
    wait_valid("t1_instr");
    chk("t1_ivld", 32'(instr_valid), 1);
    core_ready = 1'b1; #1;
    chk("t1_load", 32'(load), 1);
    PC = PC + 32'd4;
    cyc(); core_ready = 1'b0;
    chk("t1_load_pulse", 32'(load), 0);
    chk("t1_next_addr", imem_addr, 32'h4);
    chk("t1_next_req", 32'(imem_req), 1);
    chk("t1_instr_drop", instr, 32'h13);

    // Decode stalls for five cycles, then consumes
    imem_gnt = 1'b1;
    cyc(); imem_gnt = 1'b0;
    beat(32'h1111_1111, 1'b1);
    cyc(); imem_rvalid = 1'b0;
    wait_valid("t2_instr");
    for (int i = 0; i < 5; i++) begin
      chk("t2_stall_load", 32'(load), 0);
      chk("t2_stall_instr", instr, 32'h1111_1111);
      chk("t2_stall_ivld", 32'(instr_valid), 1);
      cyc();
    end
    core_ready = 1'b1; #1;
    chk("t2_load", 32'(load), 1);
    PC = PC + 32'd4;
    cyc(); core_ready = 1'b0;
    chk("t2_load_pulse", 32'(load), 0);
    chk("t2_addr", imem_addr, 32'h8);

    // A flush while in REQ has no effect
    flush = 1'b1;
    cyc(); flush = 1'b0;
    chk("fl_req_req", 32'(imem_req), 1);
    chk("fl_req_addr", imem_addr, 32'h8);

    // Flush one cycle after grant; the late beat is drained
    imem_gnt = 1'b1;
    cyc(); imem_gnt = 1'b0; flush = 1'b1;
    cyc(); flush = 1'b0;
    chk("t3_drain_ivld", 32'(instr_valid), 0);
    chk("t3_drain_req", 32'(imem_req), 0);
    cyc();
    beat(32'hDEAD_BEEF, 1'b0);
    cyc(); imem_rvalid = 1'b0;
    chk("t3_ivld", 32'(instr_valid), 0);
    chk("t3_req", 32'(imem_req), 1);
    chk("t3_addr", imem_addr, 32'h8);
    chk("t3_instr", instr, 32'h13);

    // Flush and rvalid in the same WAIT cycle return straight to REQ
    imem_gnt = 1'b1;
    cyc(); imem_gnt = 1'b0; flush = 1'b1;
    beat(32'hCAFE_0001, 1'b0);
    cyc(); flush = 1'b0; imem_rvalid = 1'b0;
    chk("t5_req", 32'(imem_req), 1);
    chk("t5_ivld", 32'(instr_valid), 0);

    // Flush in VALID overrides core_ready: the word is dropped and load stays low
    imem_gnt = 1'b1;
    cyc(); imem_gnt = 1'b0;
    beat(32'h2222_2222, 1'b1);
    cyc(); imem_rvalid = 1'b0;
    wait_valid("t4_instr");
    flush = 1'b1; core_ready = 1'b1; #1;
    chk("t4_load", 32'(load), 0);
    cyc(); flush = 1'b0; core_ready = 1'b0;
    chk("t4_ivld", 32'(instr_valid), 0);
    chk("t4_instr", instr, 32'h13);
    chk("t4_addr", imem_addr, 32'h8);

    // Misaligned PC
    PC = 32'h6; #1;
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("mis_req", 32'(imem_req), 0);
    cyc();
    chk("mis_fault", 32'(fetch_fault), 1);
    chk("mis_req2", 32'(imem_req), 0);
    PC = 32'h8;
    do_reset();
`else
    chk("mis_addr", imem_addr, 32'h4);
    chk("mis_req", 32'(imem_req), 1);
    PC = 32'h8;
`endif

    // Timeout after four WAIT cycles
    imem_gnt = 1'b1;
    cyc(); imem_gnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("to_wait_fault", 32'(fetch_fault), 0);
      cyc();
    end
    chk("to_fault", 32'(fetch_fault), 1);
    chk("to_req", 32'(imem_req), 0);
    chk("to_ivld", 32'(instr_valid), 0);
    imem_gnt = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h5555_5555;
    core_ready = 1'b1; flush = 1'b1; #1;
    chk("to_load", 32'(load), 0);
    cyc();
    imem_gnt = 1'b0; imem_rvalid = 1'b0; core_ready = 1'b0; flush = 1'b0;
    chk("to_sticky", 32'(fetch_fault), 1);
    chk("to_sticky_ivld", 32'(instr_valid), 0);
    Areset = 1'b0; #1;
    chk("to_clr_fault", 32'(fetch_fault), 0);
    cyc(); Areset = 1'b1;
    cyc();
    chk("to_restart_req", 32'(imem_req), 1);
    chk("to_restart_addr", imem_addr, 32'h8);

    // Asynchronous reset during WAIT; the late beat after release is ignored
    imem_gnt = 1'b1;
    cyc(); imem_gnt = 1'b0;
    Areset = 1'b0; #1;
    chk("ar_instr", instr, 32'h13);
    chk("ar_ivld", 32'(instr_valid), 0);
    chk("ar_req", 32'(imem_req), 0);
    chk("ar_addr", imem_addr, 32'h0);
    chk("ar_load", 32'(load), 0);
    chk("ar_fault", 32'(fetch_fault), 0);
    cyc(); Areset = 1'b1;
    beat(32'h3333_3333, 1'b0);
    cyc();
    chk("ar_late_req", 32'(imem_req), 1);
    chk("ar_late_ivld", 32'(instr_valid), 0);
    cyc(); imem_rvalid = 1'b0;
    chk("ar_late_req2", 32'(imem_req), 1);
    chk("ar_late_ivld2", 32'(instr_valid), 0);

    // Normal fetch after recovery
    imem_gnt = 1'b1;
    cyc(); imem_gnt = 1'b0;
    beat(32'h4444_4444, 1'b1);
    cyc(); imem_rvalid = 1'b0;
    wait_valid("rec_instr");
    chk("sb_empty", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
